// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Also holds the DECODE dispatch function used by both the FSM and the output decoder.
package mips_ctrl_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        IMMWB   = 4'd11,
        JUMP    = 4'd12
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
        logic       busy;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // No legal opcode dispatches back to FETCH, so a FETCH result marks an illegal opcode.
    function automatic state_t decode_target(input logic [OPC_W-1:0] op,
                                             input logic en_bne,
                                             input logic en_ori);
        state_t tgt;
        tgt = FETCH;
        case (op)
            OP_LW, OP_SW: tgt = MEMADR;
            OP_RTYPE:     tgt = EXECUTE;
            OP_BEQ:       tgt = BRANCH;
            OP_BNE:       tgt = en_bne ? BRANCH : FETCH;
            OP_ADDI:      tgt = ADDIEX;
            OP_ORI:       tgt = en_ori ? ORIEX : FETCH;
            OP_J:         tgt = JUMP;
            default:      tgt = FETCH;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder for the multicycle MIPS controller.
// Only FETCH (mem_ready), DECODE (illegal_op) and BRANCH (beq/bne select) look beyond the state.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int EN_BNE = 1,
    parameter int EN_ORI = 1
) (
    input  logic [3:0]        state,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              mem_ready,
    output logic [CTRL_W-1:0] ctrl
);

    state_t st_s;
    ctrl_t  c_s;

    assign st_s = state_t'(state);
    assign ctrl = c_s;

    // Control word per state; unlisted fields stay 0, unreachable encodings give all zeros.
    always_comb begin
        c_s = '0;
        case (st_s)
            FETCH: begin
                c_s.mem_read  = 1'b1;
                c_s.alu_src_b = SRCB_FOUR;
                c_s.alu_op    = ALU_ADD;
                c_s.pc_src    = PCSRC_ALU;
                c_s.ir_write  = mem_ready;
                c_s.pc_write  = mem_ready;
            end
            DECODE: begin
                c_s.busy       = 1'b1;
                c_s.alu_src_b  = SRCB_IMM_SH2;
                c_s.alu_op     = ALU_ADD;
                c_s.illegal_op = (decode_target(opcode, EN_BNE != 0, EN_ORI != 0) == FETCH);
            end
            MEMADR: begin
                c_s.busy      = 1'b1;
                c_s.alu_src_a = 1'b1;
                c_s.alu_src_b = SRCB_IMM;
                c_s.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                c_s.busy     = 1'b1;
                c_s.mem_read = 1'b1;
                c_s.iord     = 1'b1;
            end
            MEMWB: begin
                c_s.busy       = 1'b1;
                c_s.reg_write  = 1'b1;
                c_s.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c_s.busy      = 1'b1;
                c_s.mem_write = 1'b1;
                c_s.iord      = 1'b1;
            end
            EXECUTE: begin
                c_s.busy      = 1'b1;
                c_s.alu_src_a = 1'b1;
                c_s.alu_src_b = SRCB_REG;
                c_s.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                c_s.busy      = 1'b1;
                c_s.reg_write = 1'b1;
                c_s.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c_s.busy      = 1'b1;
                c_s.alu_src_a = 1'b1;
                c_s.alu_src_b = SRCB_REG;
                c_s.alu_op    = ALU_SUB;
                c_s.pc_src    = PCSRC_ALUOUT;
                c_s.branch    = (opcode == OP_BEQ);
                c_s.branch_ne = (EN_BNE != 0) && (opcode == OP_BNE);
            end
            ADDIEX: begin
                c_s.busy      = 1'b1;
                c_s.alu_src_a = 1'b1;
                c_s.alu_src_b = SRCB_IMM;
                c_s.alu_op    = ALU_ADD;
            end
            ORIEX: begin
                c_s.busy      = 1'b1;
                c_s.alu_src_a = 1'b1;
                c_s.alu_src_b = SRCB_IMM;
                c_s.alu_op    = ALU_OR;
            end
            IMMWB: begin
                c_s.busy      = 1'b1;
                c_s.reg_write = 1'b1;
            end
            JUMP: begin
                c_s.busy     = 1'b1;
                c_s.pc_write = 1'b1;
                c_s.pc_src   = PCSRC_JUMP;
            end
            default: c_s = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and reset masking
// of the control word produced by mips_ctrl_outdec.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int EN_BNE   = 1,
    parameter int EN_ORI   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal_op,
    output logic                busy
);

    state_t             state_q;
    state_t             state_d;
    logic [OPC_W-1:0]   op_s;
    logic [CTRL_W-1:0]  ctrl_raw_s;
    ctrl_t              ctrl_s;

    assign op_s = OPC_W'(opcode);

    // State register; reset drops straight back to FETCH from any state, including memory waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the opcode comes from the IR, which holds steady after FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE:  state_d = decode_target(op_s, EN_BNE != 0, EN_ORI != 0);
            MEMADR: begin
                if (op_s == OP_LW) begin
                    state_d = MEMRD;
                end else if (op_s == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = IMMWB;
            ORIEX:   state_d = IMMWB;
            IMMWB:   state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    mips_ctrl_outdec #(
        .EN_BNE (EN_BNE),
        .EN_ORI (EN_ORI)
    ) u_outdec (
        .state     (state_q),
        .opcode    (op_s),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw_s)
    );

    // Reset forces FETCH, but FETCH drives mem_read; mask everything while reset is held.
    always_comb begin
        if (reset) begin
            ctrl_s = '0;
        end else begin
            ctrl_s = ctrl_t'(ctrl_raw_s);
        end
    end

    assign mem_read   = ctrl_s.mem_read;
    assign mem_write  = ctrl_s.mem_write;
    assign iord       = ctrl_s.iord;
    assign ir_write   = ctrl_s.ir_write;
    assign pc_write   = ctrl_s.pc_write;
    assign branch     = ctrl_s.branch;
    assign branch_ne  = ctrl_s.branch_ne;
    assign reg_dst    = ctrl_s.reg_dst;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign reg_write  = ctrl_s.reg_write;
    assign alu_src_a  = ctrl_s.alu_src_a;
    assign alu_src_b  = ctrl_s.alu_src_b;
    assign alu_op     = ALUOP_W'(ctrl_s.alu_op);
    assign pc_src     = ctrl_s.pc_src;
    assign illegal_op = ctrl_s.illegal_op;
    assign busy       = ctrl_s.busy;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: dut_a has bne/ori enabled, dut_b has both disabled; both see identical inputs.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;

    always #5 clk = ~clk;

    logic       mr_a, mw_a, io_a, irw_a, pcw_a, br_a, bne_a, rd_a, m2r_a, rw_a, asa_a, ill_a, bsy_a;
    logic [1:0] asb_a, aop_a, pcs_a;
    logic       mr_b, mw_b, io_b, irw_b, pcw_b, br_b, bne_b, rd_b, m2r_b, rw_b, asa_b, ill_b, bsy_b;
    logic [1:0] asb_b, aop_b, pcs_b;

    mips_multicycle_controller #(.OPCODE_W(6), .ALUOP_W(2), .EN_BNE(1), .EN_ORI(1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mr_a), .mem_write(mw_a), .iord(io_a), .ir_write(irw_a), .pc_write(pcw_a),
        .branch(br_a), .branch_ne(bne_a), .reg_dst(rd_a), .mem_to_reg(m2r_a), .reg_write(rw_a),
        .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a), .pc_src(pcs_a),
        .illegal_op(ill_a), .busy(bsy_a)
    );

    mips_multicycle_controller #(.OPCODE_W(6), .ALUOP_W(2), .EN_BNE(0), .EN_ORI(0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mr_b), .mem_write(mw_b), .iord(io_b), .ir_write(irw_b), .pc_write(pcw_b),
        .branch(br_b), .branch_ne(bne_b), .reg_dst(rd_b), .mem_to_reg(m2r_b), .reg_write(rw_b),
        .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b), .pc_src(pcs_b),
        .illegal_op(ill_b), .busy(bsy_b)
    );

    // Vector order: mr mw iord irw pcw | br bne rd m2r rw | asa asb[1:0] aop[1:0] | pcs[1:0] ill busy
    logic [18:0] obs_a, obs_b;
    assign obs_a = {mr_a, mw_a, io_a, irw_a, pcw_a, br_a, bne_a, rd_a, m2r_a, rw_a,
                    asa_a, asb_a, aop_a, pcs_a, ill_a, bsy_a};
    assign obs_b = {mr_b, mw_b, io_b, irw_b, pcw_b, br_b, bne_b, rd_b, m2r_b, rw_b,
                    asa_b, asb_b, aop_b, pcs_b, ill_b, bsy_b};

    localparam logic [18:0] E_ZERO    = 19'b00000_00000_00000_0000;
    localparam logic [18:0] E_FETCH_R = 19'b10011_00000_00100_0000;
    localparam logic [18:0] E_FETCH_W = 19'b10000_00000_00100_0000;
    localparam logic [18:0] E_DEC     = 19'b00000_00000_01100_0001;
    localparam logic [18:0] E_DEC_ILL = 19'b00000_00000_01100_0011;
    localparam logic [18:0] E_MEMADR  = 19'b00000_00000_11000_0001;
    localparam logic [18:0] E_MEMRD   = 19'b10100_00000_00000_0001;
    localparam logic [18:0] E_MEMWB   = 19'b00000_00011_00000_0001;
    localparam logic [18:0] E_MEMWR   = 19'b01100_00000_00000_0001;
    localparam logic [18:0] E_EXEC    = 19'b00000_00000_10010_0001;
    localparam logic [18:0] E_ALUWB   = 19'b00000_00101_00000_0001;
    localparam logic [18:0] E_BEQ     = 19'b00000_10000_10001_0101;
    localparam logic [18:0] E_BNE     = 19'b00000_01000_10001_0101;
    localparam logic [18:0] E_ADDI    = 19'b00000_00000_11000_0001;
    localparam logic [18:0] E_ORI     = 19'b00000_00000_11011_0001;
    localparam logic [18:0] E_IMMWB   = 19'b00000_00001_00000_0001;
    localparam logic [18:0] E_JUMP    = 19'b00001_00000_00000_1001;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        string       name;
        logic [18:0] ea;
        logic [18:0] eb;
    } item_t;

    item_t sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Drive one cycle of inputs just after the rising edge and queue what both DUTs must show.
    task automatic step(input string nm, input logic rst, input logic [5:0] op,
                        input logic rdy, input logic [18:0] ea, input logic [18:0] eb);
        item_t it;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        it.name = nm;
        it.ea   = ea;
        it.eb   = eb;
        sb_q.push_back(it);
    endtask

    // Monitor: every falling edge the DUTs present a control word; compare against the queue head.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            item_t it;
            it = sb_q.pop_front();
            vectors = vectors + 2;
            if (obs_a !== it.ea) begin
                miscompares = miscompares + 1;
                $display("FAIL %s dut_a: got %b expected %b", it.name, obs_a, it.ea);
            end
            if (obs_b !== it.eb) begin
                miscompares = miscompares + 1;
                $display("FAIL %s dut_b: got %b expected %b", it.name, obs_b, it.eb);
            end
        end
    end

    initial begin
        step("reset0", 1'b1, LW, 1'b1, E_ZERO, E_ZERO);
        step("reset1", 1'b1, LW, 1'b1, E_ZERO, E_ZERO);

        // lw, no wait states: 5 cycles then FETCH
        step("lw_fetch",  1'b0, LW, 1'b1, E_FETCH_R, E_FETCH_R);
        step("lw_decode", 1'b0, LW, 1'b1, E_DEC,     E_DEC);
        step("lw_memadr", 1'b0, LW, 1'b1, E_MEMADR,  E_MEMADR);
        step("lw_memrd",  1'b0, LW, 1'b1, E_MEMRD,   E_MEMRD);
        step("lw_memwb",  1'b0, LW, 1'b1, E_MEMWB,   E_MEMWB);

        // sw with 3 not-ready cycles in MEMWR
        step("sw_fetch",  1'b0, SW, 1'b1, E_FETCH_R, E_FETCH_R);
        step("sw_decode", 1'b0, SW, 1'b1, E_DEC,     E_DEC);
        step("sw_memadr", 1'b0, SW, 1'b1, E_MEMADR,  E_MEMADR);
        for (int i = 0; i < 3; i++) begin
            step("sw_memwr_wait", 1'b0, SW, 1'b0, E_MEMWR, E_MEMWR);
        end
        step("sw_memwr_done", 1'b0, SW, 1'b1, E_MEMWR, E_MEMWR);

        // FETCH stall for 2 cycles, then an R-type
        step("rt_fetch_wait0", 1'b0, RT, 1'b0, E_FETCH_W, E_FETCH_W);
        step("rt_fetch_wait1", 1'b0, RT, 1'b0, E_FETCH_W, E_FETCH_W);
        step("rt_fetch",       1'b0, RT, 1'b1, E_FETCH_R, E_FETCH_R);
        step("rt_decode",      1'b0, RT, 1'b1, E_DEC,     E_DEC);
        step("rt_execute",     1'b0, RT, 1'b1, E_EXEC,    E_EXEC);
        step("rt_aluwb",       1'b0, RT, 1'b1, E_ALUWB,   E_ALUWB);

        step("beq_fetch",  1'b0, BEQ, 1'b1, E_FETCH_R, E_FETCH_R);
        step("beq_decode", 1'b0, BEQ, 1'b1, E_DEC,     E_DEC);
        step("beq_branch", 1'b0, BEQ, 1'b1, E_BEQ,     E_BEQ);

        // bne: dut_b traps and sits in FETCH (mem_ready low) while dut_a branches
        step("bne_fetch",  1'b0, BNE, 1'b1, E_FETCH_R, E_FETCH_R);
        step("bne_decode", 1'b0, BNE, 1'b1, E_DEC,     E_DEC_ILL);
        step("bne_branch", 1'b0, BNE, 1'b0, E_BNE,     E_FETCH_W);

        step("ori_fetch",  1'b0, ORI, 1'b1, E_FETCH_R, E_FETCH_R);
        step("ori_decode", 1'b0, ORI, 1'b1, E_DEC,     E_DEC_ILL);
        step("ori_ex",     1'b0, ORI, 1'b0, E_ORI,     E_FETCH_W);
        step("ori_immwb",  1'b0, ORI, 1'b0, E_IMMWB,   E_FETCH_W);

        step("addi_fetch",  1'b0, ADDI, 1'b1, E_FETCH_R, E_FETCH_R);
        step("addi_decode", 1'b0, ADDI, 1'b1, E_DEC,     E_DEC);
        step("addi_ex",     1'b0, ADDI, 1'b1, E_ADDI,    E_ADDI);
        step("addi_immwb",  1'b0, ADDI, 1'b1, E_IMMWB,   E_IMMWB);

        step("j_fetch",  1'b0, JMP, 1'b1, E_FETCH_R, E_FETCH_R);
        step("j_decode", 1'b0, JMP, 1'b1, E_DEC,     E_DEC);
        step("j_jump",   1'b0, JMP, 1'b1, E_JUMP,    E_JUMP);

        step("bad_fetch",  1'b0, BAD, 1'b1, E_FETCH_R,  E_FETCH_R);
        step("bad_decode", 1'b0, BAD, 1'b1, E_DEC_ILL,  E_DEC_ILL);

        // lw interrupted by reset during the MEMRD wait
        step("rlw_fetch",   1'b0, LW, 1'b1, E_FETCH_R, E_FETCH_R);
        step("rlw_decode",  1'b0, LW, 1'b1, E_DEC,     E_DEC);
        step("rlw_memadr",  1'b0, LW, 1'b0, E_MEMADR,  E_MEMADR);
        step("rlw_memrd_w", 1'b0, LW, 1'b0, E_MEMRD,   E_MEMRD);
        step("rlw_reset0",  1'b1, LW, 1'b0, E_ZERO,    E_ZERO);
        step("rlw_reset1",  1'b1, LW, 1'b0, E_ZERO,    E_ZERO);
        step("post_fetch_w", 1'b0, LW, 1'b0, E_FETCH_W, E_FETCH_W);
        step("post_fetch",   1'b0, LW, 1'b1, E_FETCH_R, E_FETCH_R);
        step("post_decode",  1'b0, LW, 1'b1, E_DEC,     E_DEC);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Main control unit for the multicycle MIPS datapath; successor to the single-cycle opcode decoder.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Adds a variable-latency memory handshake, optional bne/ori support and illegal-opcode trapping.
- Sits between the instruction register (opcode source) and the shared datapath muxes, register file, ALU control and PC logic.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of alu_op to the ALU decoder.
- EN_BNE, 1, 1 = decode bne (000101) as a branch; 0 = illegal.
- EN_ORI, 1, 1 = decode ori (001101); 0 = illegal.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  OPCODE_W  opcode from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load if ALU zero.
- branch_ne  out  1  PC load if ALU not zero.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = writeback from the memory data register.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = use funct, 11 = or.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse when an undecodable opcode is seen.
- busy  out  1  high in every state except FETCH.

Behaviour:
- Reset: while reset is high, the state is forced to FETCH and every output is held at 0. After reset deasserts, the FETCH outputs apply.
- Outputs are a pure function of state, except the mem_ready gating stated below. Every output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready. Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - lw/sw → MEMADR
  - R-type (000000) → EXECUTE
  - beq → BRANCH
  - bne (if EN_BNE) → BRANCH
  - addi → ADDIEX
  - ori (if EN_ORI) → ORIEX
  - j → JUMP
  - anything else → FETCH, with illegal_op=1 this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then → FETCH. mem_write stays high for the whole wait.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. beq asserts branch=1; bne asserts branch_ne=1. → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → IMMWB.
- ORIEX: alu_src_a=1, alu_src_b=10, alu_op=11 → IMMWB.
- IMMWB: reg_write=1, reg_dst=0 → FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- Nominal latency: lw 5, sw/R/addi/ori 4, beq/bne/j 3 cycles, plus 1 cycle per extra !mem_ready cycle in FETCH/MEMRD/MEMWR.
- The opcode used in MEMADR is the one latched in the IR. The controller does not register opcode itself, so the IR must be stable after FETCH.
- Unreachable state encodings → FETCH, with all outputs 0 in that cycle.
- Reset asserted mid-instruction (including during a memory wait) aborts immediately; no write enable may remain high.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J
  - alu_op and alu_src_b encoding constants
- Sub-module mips_ctrl_outdec: combinational state → control-word decoder. The main module keeps only the state register and next-state logic.

Test Plan:
- Reset, then lw (100011) with mem_ready=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 on cycle 5; back in FETCH on cycle 6.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write=1 and iord=1 for 4 cycles, pc_write=0 throughout, then FETCH.
- FETCH with mem_ready held 0 for 2 cycles → ir_write=0 and pc_write=0 for 2 cycles; both 1 on the ready cycle; then DECODE.
- beq vs bne (000101) with EN_BNE=1 → BRANCH with branch=1 (resp. branch_ne=1), alu_op=01, pc_src=01. With EN_BNE=0, bne gives illegal_op=1 in DECODE and returns to FETCH.
- ori (001101) → ORIEX with alu_op=11 and alu_src_b=10, then IMMWB with reg_write=1 and reg_dst=0. Opcode 111111 → illegal_op pulse, no write enable asserted.
- Reset asserted during MEMRD wait → all outputs 0 immediately; after release, FETCH outputs with mem_read=1.
